// File: rtl/sound_glu_pipe_pkg.sv
// Shared types and register addresses for the IIgs GLU sound front end.
package sound_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } glu_state_t;

  localparam logic [15:0] GLU_CTL_ADDR  = 16'hC03C;
  localparam logic [15:0] GLU_DATA_ADDR = 16'hC03D;
  localparam logic [15:0] GLU_PTRL_ADDR = 16'hC03E;
  localparam logic [15:0] GLU_PTRH_ADDR = 16'hC03F;

  // One posted sound RAM write: byte address and data.
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } glu_wentry_t;

endpackage

// File: rtl/sound_glu_pipe_wfifo.sv
// Posted-write FIFO; a push into a full FIFO is accepted when the head pops in the same cycle.
module glu_wfifo
  import sound_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  glu_wentry_t              push_data,
  input  logic                     pop,
  output glu_wentry_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  glu_wentry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage carries no reset; only pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sound_glu_pipe.sv
// GLU front end: bus slave at $C03C-$C03F, DOC register port, posted SDRAM writes,
// one-access-delayed sound RAM reads and registered volume scaling.
module sound_glu_pipe
  import sound_pkg::*;
#(
  parameter logic        ENABLE      = 1'b1,
  parameter logic [20:0] RAM_BASE    = 21'h10000,
  parameter int          WFIFO_DEPTH = 4,
  parameter logic        VOLUME_EN   = 1'b1
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        phi0,
  input  logic        m2sel_n,
  input  logic [15:0] addr,
  input  logic        rw_n,
  input  logic        data_in_strobe,
  input  logic [7:0]  data_i,
  output logic [7:0]  data_o,
  output logic        rd_en_o,
  output logic        doc_cs_n_o,
  output logic [7:0]  doc_addr_o,
  output logic [7:0]  doc_data_o,
  input  logic [7:0]  doc_data_i,
  output logic [20:0] mem_addr_o,
  output logic        mem_wr_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_byte_en_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_q_i,
  input  logic [15:0] left_mix_i,
  input  logic [15:0] right_mix_i,
  output logic [15:0] audio_l_o,
  output logic [15:0] audio_r_o,
  output logic        busy_o,
  output logic        wr_overflow_o
);

  localparam int CW = $clog2(WFIFO_DEPTH) + 1;

  glu_state_t  state, state_nxt;
  logic [6:0]  ctl;
  logic [7:0]  data_r, ptr_lo, ptr_hi;
  logic [15:0] ptr, rd_addr, byte_addr;
  logic [1:0]  lane;
  logic        rd_pend, wr_overflow;

  logic        sel, access, acc_ctl, acc_data, acc_ptrl, acc_ptrh;
  logic        ram_mode, cpu_ram_wr, cpu_ram_rd;
  logic        fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  glu_wentry_t fifo_head;

  assign sel      = ENABLE & phi0 & ~m2sel_n & (addr[15:2] == GLU_CTL_ADDR[15:2]);
  assign access   = sel & data_in_strobe;
  assign acc_ctl  = access & (addr[1:0] == GLU_CTL_ADDR[1:0]);
  assign acc_data = access & (addr[1:0] == GLU_DATA_ADDR[1:0]);
  assign acc_ptrl = access & (addr[1:0] == GLU_PTRL_ADDR[1:0]);
  assign acc_ptrh = access & (addr[1:0] == GLU_PTRH_ADDR[1:0]);

  assign ram_mode   = ctl[6];
  assign ptr        = {ptr_hi, ptr_lo};
  assign cpu_ram_wr = acc_data & ~rw_n & ram_mode;
  assign cpu_ram_rd = acc_data & rw_n & ram_mode;
  assign fifo_pop   = (state == ST_WR_REQ);

  assign rd_en_o    = sel & rw_n;
  assign doc_cs_n_o = ~(acc_data & ~rw_n & ~ram_mode);
  assign doc_addr_o = ptr_lo;
  assign doc_data_o = data_i;

  assign busy_o        = (fifo_count != '0) | rd_pend | (state != ST_IDLE);
  assign wr_overflow_o = wr_overflow;

  always_comb begin
    data_o = 8'h00;
    case (addr[1:0])
      2'b00:   data_o = {busy_o, ctl};
      2'b01:   data_o = ram_mode ? data_r : doc_data_i;
      2'b10:   data_o = ptr_lo;
      default: data_o = ptr_hi;
    endcase
  end

  glu_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
    .clk       (clk_logic),
    .rst_n     (system_reset_n),
    .push      (cpu_ram_wr),
    .push_data ({ptr, data_i}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  // NOTE: next state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty)  state_nxt = ST_WR_REQ;
        else if (rd_pend) state_nxt = ST_RD_REQ;
      end
      ST_WR_REQ:  state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: if (mem_ready_i) state_nxt = ST_IDLE;
      ST_RD_REQ:  state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (mem_ready_i) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign mem_wr_o      = (state == ST_WR_REQ);
  assign mem_rd_o      = (state == ST_RD_REQ);
  assign byte_addr     = mem_rd_o ? rd_addr : fifo_head.addr;
  assign mem_addr_o    = RAM_BASE + {7'd0, byte_addr[15:2]};
  assign mem_byte_en_o = mem_rd_o ? 4'b1111 : (4'b0001 << byte_addr[1:0]);
  assign mem_data_o    = {4{fifo_head.data}};

  // NOTE: non-blocking assignments; where two updates hit one register the later statement wins,
  // which gives CPU writes priority over read completion and a new read priority over issue.
  always_ff @(posedge clk_logic) begin
    if (!system_reset_n) begin
      ctl         <= 7'h0F;
      data_r      <= 8'h00;
      ptr_lo      <= 8'h00;
      ptr_hi      <= 8'h00;
      rd_addr     <= 16'h0000;
      rd_pend     <= 1'b0;
      lane        <= 2'b00;
      wr_overflow <= 1'b0;
    end else begin
      if (state == ST_RD_REQ) begin
        rd_pend <= 1'b0;
        lane    <= rd_addr[1:0];
      end
      if (state == ST_RD_WAIT && mem_ready_i) data_r <= mem_q_i[8*lane +: 8];
      if (cpu_ram_wr) begin
        data_r <= data_i;
        if (fifo_full && !fifo_pop) wr_overflow <= 1'b1;
      end
      if (cpu_ram_rd) begin
        rd_addr <= ptr;
        rd_pend <= 1'b1;
      end
      if (acc_ctl && !rw_n) begin
        ctl         <= data_i[6:0];
        wr_overflow <= 1'b0;
      end
      if (acc_ptrl && !rw_n) ptr_lo <= data_i;
      if (acc_ptrh && !rw_n) ptr_hi <= data_i;
      if (acc_data && ctl[5]) {ptr_hi, ptr_lo} <= ptr + 16'd1;
    end
  end

  // Gain is vol+1 (1..16); a 20-bit signed product holds 16s x 5u without overflow.
  logic signed [15:0] mix_l, mix_r;
  logic signed [5:0]  gain;
  logic signed [19:0] prod_l, prod_r;

  assign mix_l  = left_mix_i;
  assign mix_r  = right_mix_i;
  assign gain   = signed'({2'b00, ctl[3:0]} + 6'd1);
  assign prod_l = 20'(mix_l) * 20'(gain);
  assign prod_r = 20'(mix_r) * 20'(gain);

  always_ff @(posedge clk_logic) begin
    if (!system_reset_n || !ENABLE) begin
      audio_l_o <= 16'h0000;
      audio_r_o <= 16'h0000;
    end else if (VOLUME_EN) begin
      audio_l_o <= 16'(prod_l >>> 4);
      audio_r_o <= 16'(prod_r >>> 4);
    end else begin
      audio_l_o <= left_mix_i;
      audio_r_o <= right_mix_i;
    end
  end

endmodule

// File: tb/tb_sound_glu_pipe.sv
// Directed bench for sound_glu_pipe: bus accesses, a small SDRAM responder model and expected values worked by hand.
module tb_sound_glu_pipe;
  import sound_pkg::*;

  localparam logic [20:0] RAM_BASE = 21'h10000;

  logic        clk_logic = 1'b0;
  logic        system_reset_n;
  logic        phi0, m2sel_n, rw_n, data_in_strobe;
  logic [15:0] addr;
  logic [7:0]  data_i, data_o, doc_addr_o, doc_data_o, doc_data_i;
  logic        rd_en_o, doc_cs_n_o;
  logic [20:0] mem_addr_o;
  logic        mem_wr_o, mem_rd_o;
  logic [3:0]  mem_byte_en_o;
  logic [31:0] mem_data_o;
  logic        mem_ready_i = 1'b0;
  logic [31:0] mem_q_i = 32'h0;
  logic [15:0] left_mix_i, right_mix_i, audio_l_o, audio_r_o;
  logic        busy_o, wr_overflow_o;

  sound_glu_pipe dut (
    .clk_logic(clk_logic), .system_reset_n(system_reset_n), .phi0(phi0), .m2sel_n(m2sel_n),
    .addr(addr), .rw_n(rw_n), .data_in_strobe(data_in_strobe), .data_i(data_i),
    .data_o(data_o), .rd_en_o(rd_en_o), .doc_cs_n_o(doc_cs_n_o), .doc_addr_o(doc_addr_o),
    .doc_data_o(doc_data_o), .doc_data_i(doc_data_i), .mem_addr_o(mem_addr_o),
    .mem_wr_o(mem_wr_o), .mem_rd_o(mem_rd_o), .mem_byte_en_o(mem_byte_en_o),
    .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i), .mem_q_i(mem_q_i),
    .left_mix_i(left_mix_i), .right_mix_i(right_mix_i), .audio_l_o(audio_l_o),
    .audio_r_o(audio_r_o), .busy_o(busy_o), .wr_overflow_o(wr_overflow_o)
  );

  always #5 clk_logic = ~clk_logic;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // SDRAM model: each request answers with a ready pulse two cycles later unless held.
  logic [31:0] sram [16384];
  logic [20:0] wr_addr_q [$];
  logic [3:0]  wr_be_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_events = 0, rd_events = 0, wr_at_rd = 0;
  logic        hold_ready = 1'b0, resp_pending = 1'b0;
  int          resp_delay = 0;
  logic [31:0] resp_q = 32'h0;
  logic [13:0] idx;

  initial for (int i = 0; i < 16384; i++) sram[i] = 32'h0;

  always @(negedge clk_logic) begin
    mem_ready_i = 1'b0;
    if (resp_pending && !hold_ready) begin
      if (resp_delay == 0) begin
        mem_ready_i  = 1'b1;
        mem_q_i      = resp_q;
        resp_pending = 1'b0;
      end else begin
        resp_delay--;
      end
    end
    idx = 14'(mem_addr_o - RAM_BASE);
    if (mem_wr_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_byte_en_o[b]) sram[idx][8*b +: 8] = mem_data_o[8*b +: 8];
      wr_addr_q.push_back(mem_addr_o);
      wr_be_q.push_back(mem_byte_en_o);
      wr_data_q.push_back(mem_data_o);
      wr_events++;
      resp_q       = 32'hDEADBEEF;
      resp_pending = 1'b1;
      resp_delay   = 1;
    end
    if (mem_rd_o) begin
      resp_q       = sram[idx];
      rd_events++;
      wr_at_rd     = wr_events;
      resp_pending = 1'b1;
      resp_delay   = 1;
    end
  end

  task automatic bus_start(input logic [15:0] a, input logic rd, input logic [7:0] d);
    @(negedge clk_logic);
    phi0 = 1'b1; m2sel_n = 1'b0; addr = a; rw_n = rd; data_i = d; data_in_strobe = 1'b1;
    #1;
  endtask

  task automatic bus_end();
    @(negedge clk_logic);
    phi0 = 1'b0; m2sel_n = 1'b1; rw_n = 1'b1; data_in_strobe = 1'b0;
    repeat (2) @(negedge clk_logic);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    bus_start(a, 1'b0, d);
    bus_end();
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic en);
    bus_start(a, 1'b1, 8'h00);
    d  = data_o;
    en = rd_en_o;
    bus_end();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      @(negedge clk_logic);
      n++;
    end
    check(tag, busy_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [7:0] rd;
  logic       en;
  int         wr_base, rd_base, q_base;

  initial begin
    system_reset_n = 1'b0;
    phi0 = 1'b0; m2sel_n = 1'b1; addr = 16'h0000; rw_n = 1'b1;
    data_in_strobe = 1'b0; data_i = 8'h00; doc_data_i = 8'h00;
    left_mix_i = 16'h1234; right_mix_i = 16'h1234;

    // Reset state
    repeat (3) @(posedge clk_logic);
    @(negedge clk_logic);
    check("rst_audio_l", audio_l_o, 16'h0000);
    check("rst_audio_r", audio_r_o, 16'h0000);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ovf", wr_overflow_o, 1'b0);
    check("rst_doc_cs_n", doc_cs_n_o, 1'b1);
    check("rst_mem_strobes", {mem_wr_o, mem_rd_o}, 2'b00);
    check("rst_rd_en_idle", rd_en_o, 1'b0);
    system_reset_n = 1'b1;
    left_mix_i = 16'h0000; right_mix_i = 16'h0000;
    bus_read(16'hC03C, rd, en);
    check("rst_ctl", rd, 8'h0F);
    check("rd_en_on_read", en, 1'b1);
    bus_read(16'hC03E, rd, en);
    check("rst_ptr_lo", rd, 8'h00);
    bus_read(16'hC03F, rd, en);
    check("rst_ptr_hi", rd, 8'h00);

    // Auto-increment RAM writes from $1236: word $48D, lanes 2 and 3
    bus_write(16'hC03C, 8'h60);
    bus_write(16'hC03E, 8'h36);
    bus_write(16'hC03F, 8'h12);
    q_base = wr_addr_q.size();
    bus_write(16'hC03D, 8'hAA);
    bus_write(16'hC03D, 8'hBB);
    wait_idle("burst_idle");
    check("burst_count", wr_addr_q.size() - q_base, 2);
    if (wr_addr_q.size() >= q_base + 2) begin
      check("burst_addr0", wr_addr_q[q_base], RAM_BASE + 21'h48D);
      check("burst_be0", wr_be_q[q_base], 4'b0100);
      check("burst_data0", wr_data_q[q_base], 32'hAAAAAAAA);
      check("burst_addr1", wr_addr_q[q_base+1], RAM_BASE + 21'h48D);
      check("burst_be1", wr_be_q[q_base+1], 4'b1000);
      check("burst_data1", wr_data_q[q_base+1], 32'hBBBBBBBB);
    end
    bus_read(16'hC03E, rd, en);
    check("burst_ptr_lo", rd, 8'h38);
    bus_read(16'hC03F, rd, en);
    check("burst_ptr_hi", rd, 8'h12);

    // Delayed read: first read returns stale data_r, fetch waits behind the writes
    bus_write(16'hC03C, 8'h40);
    bus_write(16'hC03F, 8'h00);
    bus_write(16'hC03E, 8'h10);
    wr_base = wr_events;
    rd_base = rd_events;
    bus_write(16'hC03D, 8'h5A);
    bus_write(16'hC03E, 8'h20);
    bus_write(16'hC03D, 8'hC3);
    bus_write(16'hC03E, 8'h10);
    bus_read(16'hC03D, rd, en);
    check("dread_stale", rd, 8'hC3);
    wait_idle("dread_idle");
    check("dread_fetches", rd_events - rd_base, 1);
    check("dread_after_writes", wr_at_rd, wr_base + 2);
    bus_read(16'hC03D, rd, en);
    check("dread_fresh", rd, 8'h5A);
    wait_idle("dread_idle2");

    // Overflow: one write in flight, four queued, sixth dropped
    hold_ready = 1'b1;
    bus_write(16'hC03E, 8'h00);
    bus_write(16'hC03F, 8'h01);
    wr_base = wr_events;
    q_base  = wr_data_q.size();
    for (int i = 1; i <= 6; i++) bus_write(16'hC03D, 8'(i));
    check("ovf_flag", wr_overflow_o, 1'b1);
    check("ovf_busy", busy_o, 1'b1);
    check("ovf_inflight", wr_events - wr_base, 1);
    hold_ready = 1'b0;
    wait_idle("ovf_idle");
    check("ovf_drained", wr_events - wr_base, 5);
    if (wr_data_q.size() == q_base + 5)
      check("ovf_last_data", wr_data_q[q_base+4], 32'h05050505);
    bus_write(16'hC03C, 8'h40);
    check("ovf_clear", wr_overflow_o, 1'b0);

    // DOC-mode write at $FFFF with auto-increment
    bus_write(16'hC03C, 8'h20);
    bus_write(16'hC03E, 8'hFF);
    bus_write(16'hC03F, 8'hFF);
    wr_base = wr_events;
    bus_start(16'hC03D, 1'b0, 8'h77);
    check("doc_cs_low", doc_cs_n_o, 1'b0);
    check("doc_addr", doc_addr_o, 8'hFF);
    check("doc_data", doc_data_o, 8'h77);
    bus_end();
    check("doc_cs_high", doc_cs_n_o, 1'b1);
    bus_read(16'hC03E, rd, en);
    check("doc_ptr_lo_wrap", rd, 8'h00);
    bus_read(16'hC03F, rd, en);
    check("doc_ptr_hi_wrap", rd, 8'h00);
    doc_data_i = 8'hC5;
    bus_read(16'hC03D, rd, en);
    check("doc_read", rd, 8'hC5);
    bus_read(16'hC03E, rd, en);
    check("doc_read_inc", rd, 8'h01);
    check("doc_no_mem", wr_events - wr_base, 0);

    // Volume scaling, one cycle registered latency
    bus_write(16'hC03C, 8'h0F);
    @(negedge clk_logic);
    left_mix_i = 16'h7FFF; right_mix_i = 16'h8000;
    #1;
    check("vol_latency_l", audio_l_o, 16'h0000);
    @(posedge clk_logic); #1;
    check("vol15_l", audio_l_o, 16'h7FFF);
    check("vol15_r", audio_r_o, 16'h8000);
    bus_write(16'hC03C, 8'h07);
    check("vol7_l", audio_l_o, 16'h3FFF);
    check("vol7_r", audio_r_o, 16'hC000);
    bus_write(16'hC03C, 8'h00);
    @(negedge clk_logic);
    left_mix_i = 16'h8000; right_mix_i = 16'h0010;
    @(posedge clk_logic); #1;
    check("vol0_l", audio_l_o, 16'hF800);
    check("vol0_r", audio_r_o, 16'h0001);

    // Reset during WR_WAIT with a second entry queued, then a stale ready
    hold_ready = 1'b1;
    bus_write(16'hC03C, 8'h40);
    bus_write(16'hC03E, 8'h40);
    wr_base = wr_events;
    bus_write(16'hC03D, 8'h11);
    bus_write(16'hC03D, 8'h22);
    check("rstw_inflight", wr_events - wr_base, 1);
    @(negedge clk_logic);
    system_reset_n = 1'b0;
    repeat (2) @(negedge clk_logic);
    system_reset_n = 1'b1;
    hold_ready = 1'b0;
    repeat (6) @(negedge clk_logic);
    check("rstw_busy", busy_o, 1'b0);
    check("rstw_no_more_writes", wr_events - wr_base, 1);
    bus_read(16'hC03C, rd, en);
    check("rstw_ctl", rd, 8'h0F);
    bus_write(16'hC03C, 8'h40);
    bus_read(16'hC03D, rd, en);
    check("rstw_data_r", rd, 8'h00);
    wait_idle("rstw_idle");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
